// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks an active-low row strobe, debounces the column lines and
// reports press/release strobes. Define KEYPAD_AUTO_REPEAT_EN to auto-repeat key_valid while held.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int REPEAT_DLY   = 500000,
    parameter int REPEAT_RATE  = 100000,
    localparam int CODE_W      = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   column,
    output logic [ROWS-1:0]   row_n,
    output logic [CODE_W-1:0] key_code,
    output logic              press,
    output logic              key_valid,
    output logic              key_release
);

    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DB_W    = $clog2(DEBOUNCE_CNT + 1);

    localparam bit PARAMS_OK = (ROWS >= 2) && (ROWS <= 16) && (COLS >= 2) && (COLS <= 16) &&
                               (SCAN_DIV >= 4) && (DEBOUNCE_CNT >= 1) &&
                               (REPEAT_DLY >= 1) && (REPEAT_RATE >= 1);

    if (!PARAMS_OK) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELDB} state_t;

    function automatic logic one_low(input logic [COLS-1:0] col);
        return $countones(~col) == 1;
    endfunction

    function automatic logic [COL_W-1:0] col_index(input logic [COLS-1:0] col);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col[c]) idx = COL_W'(c);
        end
        return idx;
    endfunction

    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
        return (r == ROW_W'(ROWS - 1)) ? '0 : r + 1'b1;
    endfunction

    function automatic logic [CODE_W-1:0] key_index(input logic [ROW_W-1:0] r,
                                                    input logic [COLS-1:0]  col);
        return CODE_W'(r) * CODE_W'(COLS) + CODE_W'(col_index(col));
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous column lines
    logic [COLS-1:0] col_p0, col_p1, col_s;

    always_ff @(posedge clk) begin
        col_p0 <= column;
        col_p1 <= col_p0;
    end

    assign col_s = col_p1;

    state_t             state, state_nx;
    logic [ROW_W-1:0]   row_idx, row_nx;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nx;
    logic [DB_W-1:0]    db_cnt, db_nx;
    logic [COLS-1:0]    cand_col, cand_nx;
    logic [CODE_W-1:0]  code_nx;
    logic               press_nx, valid_nx, release_nx;

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
`endif

    always_comb begin
        state_nx   = state;
        row_nx     = row_idx;
        dwell_nx   = dwell_cnt;
        db_nx      = db_cnt;
        cand_nx    = cand_col;
        code_nx    = key_code;
        press_nx   = press;
        valid_nx   = 1'b0;
        release_nx = 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
        hold_nx    = '0;
`endif
        case (state)
            SCAN: begin
                if (dwell_cnt == DWELL_W'(SCAN_DIV - 1)) begin
                    dwell_nx = '0;
                    if (one_low(col_s)) begin
                        state_nx = DEBOUNCE;
                        cand_nx  = col_s;
                        db_nx    = '0;
                    end else begin
                        row_nx = next_row(row_idx);
                    end
                end else begin
                    dwell_nx = dwell_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_s == cand_col) begin
                    if (db_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
                        state_nx = PRESSED;
                        code_nx  = key_index(row_idx, cand_col);
                        press_nx = 1'b1;
                        valid_nx = 1'b1;
                        db_nx    = '0;
                    end else begin
                        db_nx = db_cnt + 1'b1;
                    end
                end else begin
                    // Bounce: retry the same row from a fresh dwell
                    state_nx = SCAN;
                    dwell_nx = '0;
                    db_nx    = '0;
                end
            end
            PRESSED: begin
                if (col_s != cand_col) begin
                    state_nx = RELDB;
                    db_nx    = '0;
                end
`ifdef KEYPAD_AUTO_REPEAT_EN
                else begin
                    hold_nx = hold_cnt + 1'b1;
                    if (hold_nx == HOLD_W'(REPEAT_DLY)) begin
                        valid_nx = 1'b1;
                    end else if (hold_nx == HOLD_W'(REPEAT_DLY + REPEAT_RATE)) begin
                        valid_nx = 1'b1;
                        hold_nx  = HOLD_W'(REPEAT_DLY);
                    end
                end
`endif
            end
            RELDB: begin
                if (col_s == cand_col) begin
                    state_nx = PRESSED;
                    db_nx    = '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
                    state_nx   = SCAN;
                    press_nx   = 1'b0;
                    release_nx = 1'b1;
                    row_nx     = next_row(row_idx);
                    dwell_nx   = '0;
                    db_nx      = '0;
                end else begin
                    db_nx = db_cnt + 1'b1;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            row_idx     <= '0;
            dwell_cnt   <= '0;
            db_cnt      <= '0;
            cand_col    <= '1;
            key_code    <= '0;
            press       <= 1'b0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            state       <= state_nx;
            row_idx     <= row_nx;
            dwell_cnt   <= dwell_nx;
            db_cnt      <= db_nx;
            cand_col    <= cand_nx;
            key_code    <= code_nx;
            press       <= press_nx;
            key_valid   <= valid_nx;
            key_release <= release_nx;
`ifdef KEYPAD_AUTO_REPEAT_EN
            hold_cnt    <= hold_nx;
`endif
        end
    end

    assign row_n = ~(ROWS'(1) << row_idx);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a row-aware keypad model and an event scoreboard.
module tb_keypad_scanner;

    localparam int ROWS         = 4;
    localparam int COLS         = 3;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int REPEAT_DLY   = 10;
    localparam int REPEAT_RATE  = 5;

    typedef struct {
        bit         is_rel;
        logic [3:0] code;
        int         dt;
    } evt_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [COLS-1:0] column;
    logic [ROWS-1:0] row_n;
    logic [3:0]      key_code;
    logic            press, key_valid, key_release;

    logic            key_down  = 1'b0;
    logic [1:0]      key_r     = '0;
    logic [1:0]      key_c     = '0;
    logic            use_force = 1'b0;
    logic [2:0]      col_force = '1;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_evt = 0;
    evt_t exp_q[$];

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .clk(clk), .rst(rst), .column(column), .row_n(row_n), .key_code(key_code),
        .press(press), .key_valid(key_valid), .key_release(key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A held key pulls its column low only while its row is driven
    always_comb begin
        column = '1;
        if (use_force) column = col_force;
        else if (key_down && !row_n[key_r]) column[key_c] = 1'b0;
    end

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_evt(input bit rel, input logic [3:0] code, input int dt);
        evt_t e;
        e.is_rel = rel;
        e.code   = code;
        e.dt     = dt;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s pending=%0d expected=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_row_start(input int r, input int budget);
        logic [3:0] prev;
        int         n;
        bit         hit;
        prev = row_n;
        n    = 0;
        hit  = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (row_n === row_pat(r) && prev !== row_pat(r)) hit = 1'b1;
            prev = row_n;
        end
        total++;
        assert (hit) else begin
            bad++;
            $error("FAIL row_start%0d observed=timeout expected=entry", r);
        end
    endtask

    initial begin : monitor
        evt_t e;
        forever begin
            @(negedge clk);
            if (!rst && (key_valid || key_release)) begin
                total++;
                assert (!(key_valid && key_release)) else begin
                    bad++;
                    $error("FAIL strobe_overlap observed=both expected=one");
                end
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_event observed=valid%0b/release%0b code=%0d expected=none",
                           key_valid, key_release, key_code);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("evt_kind", 32'(key_release), 32'(e.is_rel));
                    check("evt_code", 32'(key_code), 32'(e.code));
                    if (e.dt != 0) check("evt_spacing", cyc - last_evt, e.dt);
                end
                last_evt = cyc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int         n;
        int         changes;
        logic [3:0] prev;

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_row_n", 32'(row_n), 32'(4'b1110));
        check("rst_key_code", 32'(key_code), 0);
        check("rst_press", 32'(press), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_key_release", 32'(key_release), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle scan: each row held SCAN_DIV cycles, then wrap
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            check("idle_row", 32'(row_n), 32'(row_pat((i / 4) % 4)));
            check("idle_flags", 32'({press, key_valid, key_release}), 0);
        end

        // Clean press of key 3 on row 1, then release
        wait_row_start(1, 40);
        key_r = 2'd1; key_c = 2'd0; key_down = 1'b1;
        expect_evt(1'b0, 4'd3, 0);
        drain("press_k3", 60);
        @(negedge clk);
        check("k3_code", 32'(key_code), 3);
        check("k3_press", 32'(press), 1);
        check("k3_row_frozen", 32'(row_n), 32'(4'b1101));
        key_down = 1'b0;
        expect_evt(1'b1, 4'd3, 0);
        drain("release_k3", 60);
        @(negedge clk);
        check("k3_released", 32'(press), 0);
        check("k3_next_row", 32'(row_n), 32'(row_pat(2)));

        // Bouncing column must not register, then a stable key 7
        use_force = 1'b1;
        for (int i = 0; i < 24; i++) begin
            col_force = (i % 4 < 2) ? 3'b101 : 3'b111;
            @(negedge clk);
        end
        use_force = 1'b0;
        col_force = '1;
        key_r = 2'd2; key_c = 2'd1; key_down = 1'b1;
        expect_evt(1'b0, 4'd7, 0);
        drain("press_k7", 80);
        @(negedge clk);
        check("k7_code", 32'(key_code), 7);
        check("k7_press", 32'(press), 1);
        key_down = 1'b0;
        expect_evt(1'b1, 4'd7, 0);
        drain("release_k7", 60);

        // Two columns low on every row is a ghost: keep scanning
        use_force = 1'b1;
        col_force = 3'b100;
        changes = 0;
        @(negedge clk);
        prev = row_n;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (row_n !== prev) changes++;
            prev = row_n;
        end
        check("ghost_row_steps", changes, 12);
        check("ghost_press", 32'(press), 0);
        use_force = 1'b0;
        col_force = '1;

        // Reset while key 11 is held aborts silently, then the key is found again
        key_r = 2'd3; key_c = 2'd2; key_down = 1'b1;
        expect_evt(1'b0, 4'd11, 0);
        drain("press_k11", 80);
        @(negedge clk);
        check("k11_code", 32'(key_code), 11);
        check("k11_press", 32'(press), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_row_n", 32'(row_n), 32'(4'b1110));
        check("midrst_key_code", 32'(key_code), 0);
        check("midrst_press", 32'(press), 0);
        check("midrst_flags", 32'({key_valid, key_release}), 0);
        expect_evt(1'b0, 4'd11, 0);
        drain("repress_k11", 80);
        key_down = 1'b0;
        expect_evt(1'b1, 4'd11, 0);
        drain("release_k11", 60);

        // Hold key 0; auto-repeat builds add pulses at +10, +15, +20, +25
        key_r = 2'd0; key_c = 2'd0; key_down = 1'b1;
        expect_evt(1'b0, 4'd0, 0);
`ifdef KEYPAD_AUTO_REPEAT_EN
        expect_evt(1'b0, 4'd0, REPEAT_DLY);
        expect_evt(1'b0, 4'd0, REPEAT_RATE);
        expect_evt(1'b0, 4'd0, REPEAT_RATE);
        expect_evt(1'b0, 4'd0, REPEAT_RATE);
`endif
        n = 0;
        while (key_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("k0_accept_seen", 32'(key_valid), 1);
        check("k0_code", 32'(key_code), 0);
        repeat (26) @(negedge clk);
        check("k0_still_held", 32'(press), 1);
        key_down = 1'b0;
        expect_evt(1'b1, 4'd0, 0);
        drain("hold_k0", 80);
        @(negedge clk);
        check("k0_released", 32'(press), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
